ex_sequencer: RTL and testbench
===============================

# ex_sequencer

EX-stage controller, the multi-cycle successor to the combinational EX control decode. It decodes RV32IM R/I-type arithmetic, drives the ALU, multiply-unit (MU) and divide-unit (DU) controls, and sequences start/done handshakes for the multi-cycle units. While a multi-cycle op is in flight it stalls the upstream pipeline, then presents the result with a valid/ready handshake. It sits between ID/EX and EX/MEM, alongside the ALU, MU and DU datapaths.

## Interface
Parameters:
- N_RES, 3, number of result sources on the EX result mux (0 ALU, 1 MU, 2 DU, others reserved); must be ≥3
- MAX_WAIT, 64, cycles a multi-cycle unit may stay busy before timeout abort
Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded op present from ID/EX
- in_ready  out  1  op accepted this cycle
- opcode  in  7  instruction opcode
- func3  in  3  instruction func3
- func7b50  in  2  {func7[5], func7[0]}
- flush  in  1  kill any accepted, in-flight op
- mul_done  in  1  MU result ready (1-cycle pulse)
- div_done  in  1  DU result ready (1-cycle pulse)
- out_ready  in  1  EX/MEM can accept result
- aluctl  out  4  ALU operation
- mulctl  out  2  MU op: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu
- divctl  out  2  DU op: 00 div, 01 divu, 10 rem, 11 remu
- mulstart  out  1  1-cycle MU start pulse
- divstart  out  1  1-cycle DU start pulse
- ifuresctl  out  $clog2(N_RES)  result mux select
- out_valid  out  1  result valid to EX/MEM
- stall  out  1  hold upstream stages
- timeout  out  1  1-cycle pulse on watchdog abort

## Operation
- Arith ops: opcode matching 0?10011. M-op: opcode 0110011 and func7b50==01; func3[2]=0 → MUL, else DIV. Other opcodes: aluctl=0000 (add), ifuresctl=0, treated as ALU op.
- aluctl: add 0000, sub 0001, xor 0010, or 0011, and 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
- func3 000: sub only for R-type (opcode 0110011) with func7b50[1]=1; I-type (0010011) always add. func3 101: sra iff func7b50[1]=1, both types.
- mulctl/divctl = func3[1:0]; captured into registers at accept, held stable until return to IDLE.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT, RESULT.
- IDLE: ALU op: in_ready=out_ready, out_valid=in_valid, ifuresctl=0, combinational pass-through. MUL op with in_valid: accept (in_ready=1), mulstart=1 that cycle, → MUL_WAIT. DIV analogous with divstart → DIV_WAIT.
- MUL_WAIT/DIV_WAIT: stall=1, in_ready=0; matching done → RESULT. Non-matching done ignored.
- RESULT: out_valid=1, ifuresctl=1 (MUL) or 2 (DIV), stall=1; out_ready=1 → IDLE.
- Watchdog: counter reset at entry to a WAIT state, increments each WAIT cycle; count reaching MAX_WAIT without done → timeout pulse, → IDLE, no out_valid.
- flush: highest priority; any state → IDLE next cycle; no start, no out_valid that cycle; done pulses arriving in IDLE ignored.

## Timing
- Reset: state IDLE, counter 0, registered mulctl/divctl 00; mulstart, divstart, timeout, out_valid, stall 0; ifuresctl 0; aluctl 0000.
- ALU latency 0 cycles (combinational through IDLE).
- MUL/DIV: start in accept cycle T; done at T+k → out_valid from T+k+1; earliest new accept T+k+2 (if out_ready at T+k+1).
- done in the same cycle as the start pulse is ignored (unit cannot respond in 0 cycles).
- done and flush same cycle: flush wins.
- done in the cycle the counter reaches MAX_WAIT: done wins, no timeout.
- Start pulses never exceed one cycle; never asserted outside IDLE.

## Structure
- Shared package ex_pkg: aluctl encodings, mulctl/divctl encodings, result-source indices, opcode constants, FSM state enum.
- Sub-module ex_decode: combinational opcode/func decode (aluctl, is_mul, is_div, op subcodes); ex_sequencer holds FSM, watchdog, output registers.

## Test plan
- R-type sub (0110011, func3 000, func7b50 10), out_ready=1 → aluctl=0001, out_valid same cycle, ifuresctl=0, stall=0; addi with func7b50 10 → aluctl=0000.
- mulh (func3 001, func7b50 01), mul_done 4 cycles later, out_ready=1 → one mulstart pulse, mulctl=01 held, stall 5 cycles, out_valid 1 cycle with ifuresctl=1.
- remu (func3 111), div_done after 10 cycles, out_ready low 3 cycles → divctl=11, out_valid held 3 cycles in RESULT until out_ready, then IDLE.
- div with no div_done, MAX_WAIT=64 → timeout pulse after 64 WAIT cycles, back to IDLE, out_valid never asserted.
- flush in MUL_WAIT, then mul_done next cycle → IDLE, done ignored, no out_valid.
- Reset asserted mid DIV_WAIT → all outputs at reset values immediately; after release, new ALU op handled normally.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the EX-stage controller.
//   - ALU operation encodings (aluctl)
//   - MU / DU sub-operation encodings (mulctl / divctl)
//   - EX result-mux source indices
//   - Opcode constants and the arithmetic-opcode match helper
//   - Sequencer FSM state enum
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [1:0] MU_MUL    = 2'b00;
  localparam logic [1:0] MU_MULH   = 2'b01;
  localparam logic [1:0] MU_MULHSU = 2'b10;
  localparam logic [1:0] MU_MULHU  = 2'b11;

  localparam logic [1:0] DU_DIV  = 2'b00;
  localparam logic [1:0] DU_DIVU = 2'b01;
  localparam logic [1:0] DU_REM  = 2'b10;
  localparam logic [1:0] DU_REMU = 2'b11;

  localparam int RES_ALU = 0;
  localparam int RES_MU  = 1;
  localparam int RES_DU  = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // R-type and I-type arithmetic differ only in bit 5: 0?10011
  localparam logic [6:0] OPC_ARITH_MASK = 7'b1011111;
  localparam logic [6:0] OPC_ARITH_VAL  = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_RESULT
  } state_e;

  function automatic logic is_arith(input logic [6:0] opcode);
    return (opcode & OPC_ARITH_MASK) == OPC_ARITH_VAL;
  endfunction

endpackage

// File: rtl/ex_sequencer_if.sv
// ex_sequencer_if: ID/EX -> EX -> EX/MEM handshake and decoded-op fields.
//   in_valid/in_ready : op offered by ID/EX, accepted by EX
//   opcode/func3/func7b50 : instruction fields of the offered op
//   out_valid/out_ready : result offered by EX, accepted by EX/MEM
//   master : the pipeline around EX (drives op and out_ready)
//   slave  : the EX sequencer
interface ex_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [1:0] func7b50;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid, opcode, func3, func7b50, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, opcode, func3, func7b50, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/ex_decode.sv
// ex_decode: combinational RV32IM arithmetic decode.
//   opcode/func3/func7b50 in : instruction fields ({func7[5], func7[0]})
//   aluctl out : ALU operation (add for non-arithmetic opcodes and M-ops)
//   is_mul/is_div out : op belongs to the multiply / divide unit
//   subop out : MU/DU sub-operation, func3[1:0]
module ex_decode
  import ex_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [1:0] func7b50,
  output alu_op_e    aluctl,
  output logic       is_mul,
  output logic       is_div,
  output logic [1:0] subop
);

  logic is_m;

  assign is_m   = (opcode == OPC_OP) && (func7b50 == 2'b01);
  assign is_mul = is_m && !func3[2];
  assign is_div = is_m && func3[2];
  assign subop  = func3[1:0];

  always_comb begin
    aluctl = ALU_ADD;
    if (is_arith(opcode) && !is_m) begin
      case (func3)
        // I-type has no subtract; func7 bits there are immediate bits
        3'b000: aluctl = (opcode == OPC_OP && func7b50[1]) ? ALU_SUB : ALU_ADD;
        3'b001: aluctl = ALU_SLL;
        3'b010: aluctl = ALU_SLT;
        3'b011: aluctl = ALU_SLTU;
        3'b100: aluctl = ALU_XOR;
        3'b101: aluctl = func7b50[1] ? ALU_SRA : ALU_SRL;
        3'b110: aluctl = ALU_OR;
        3'b111: aluctl = ALU_AND;
        default: aluctl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/ex_sequencer.sv
// ex_sequencer: EX-stage controller for ALU, multiply and divide units.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : op handshake from ID/EX and result handshake to EX/MEM
//   flush      : kill any accepted / in-flight op
//   mul_done, div_done : 1-cycle completion pulses from MU / DU
//   aluctl     : ALU operation (combinational in IDLE, else add)
//   mulctl, divctl : MU / DU sub-op, held from accept until next accept
//   mulstart, divstart : 1-cycle start pulses, only from IDLE
//   ifuresctl  : EX result mux select (0 ALU, 1 MU, 2 DU)
//   stall      : hold upstream while a multi-cycle op is pending
//   timeout    : 1-cycle pulse when a unit stays busy MAX_WAIT cycles
module ex_sequencer
  import ex_pkg::*;
#(
  parameter int N_RES    = 3,
  parameter int MAX_WAIT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ex_sequencer_if.slave            bus,
  input  logic                     flush,
  input  logic                     mul_done,
  input  logic                     div_done,
  output logic [3:0]               aluctl,
  output logic [1:0]               mulctl,
  output logic [1:0]               divctl,
  output logic                     mulstart,
  output logic                     divstart,
  output logic [$clog2(N_RES)-1:0] ifuresctl,
  output logic                     stall,
  output logic                     timeout
);

  localparam int RW = $clog2(N_RES);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    mulctl_r, divctl_r;
  logic          src_div;
  logic          in_ready_c, out_valid_c;

  alu_op_e    d_aluctl;
  logic       d_is_mul, d_is_div;
  logic [1:0] d_subop;

  ex_decode u_decode (
    .opcode   (bus.opcode),
    .func3    (bus.func3),
    .func7b50 (bus.func7b50),
    .aluctl   (d_aluctl),
    .is_mul   (d_is_mul),
    .is_div   (d_is_div),
    .subop    (d_subop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mulctl_r <= 2'b00;
      divctl_r <= 2'b00;
      src_div  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mulstart || divstart) begin
        cnt     <= '0;
        src_div <= divstart;
      end else if (state == S_MUL_WAIT || state == S_DIV_WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (mulstart) mulctl_r <= d_subop;
      if (divstart) divctl_r <= d_subop;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    mulstart    = 1'b0;
    divstart    = 1'b0;
    stall       = 1'b0;
    timeout     = 1'b0;
    ifuresctl   = RW'(RES_ALU);
    aluctl      = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (!flush) begin
          if (bus.in_valid && d_is_mul) begin
            in_ready_c = 1'b1;
            mulstart   = 1'b1;
            state_nxt  = S_MUL_WAIT;
          end else if (bus.in_valid && d_is_div) begin
            in_ready_c = 1'b1;
            divstart   = 1'b1;
            state_nxt  = S_DIV_WAIT;
          end else begin
            // ALU ops flow straight through; EX/MEM backpressure reaches ID/EX
            in_ready_c  = bus.out_ready;
            out_valid_c = bus.in_valid;
            if (bus.in_valid) aluctl = d_aluctl;
          end
        end
      end
      S_MUL_WAIT, S_DIV_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if ((state == S_MUL_WAIT) ? mul_done : div_done) begin
          state_nxt = S_RESULT;
        end else if (cnt == CW'(MAX_WAIT - 1)) begin
          // this is the MAX_WAIT-th busy cycle; done still had priority above
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RESULT: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          out_valid_c = 1'b1;
          ifuresctl   = src_div ? RW'(RES_DU) : RW'(RES_MU);
          if (bus.out_ready) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sub-op is visible in the start cycle itself, then from the held register
  assign mulctl = mulstart ? d_subop : mulctl_r;
  assign divctl = divstart ? d_subop : divctl_r;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_ex_sequencer.sv
module tb_ex_sequencer;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       mul_done = 1'b0;
  logic       div_done = 1'b0;
  logic [3:0] aluctl;
  logic [1:0] mulctl, divctl;
  logic       mulstart, divstart, stall, timeout;
  logic [1:0] ifuresctl;

  int n_cmp = 0;
  int n_err = 0;

  int n_st, n_start, n_ov, n_ovw, n_to, to_c, n_ctlbad, n_resbad;

  ex_sequencer_if bus ();

  ex_sequencer #(.N_RES(3), .MAX_WAIT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .mul_done  (mul_done),
    .div_done  (div_done),
    .aluctl    (aluctl),
    .mulctl    (mulctl),
    .divctl    (divctl),
    .mulstart  (mulstart),
    .divstart  (divstart),
    .ifuresctl (ifuresctl),
    .stall     (stall),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7);
    bus.opcode   = op;
    bus.func3    = f3;
    bus.func7b50 = f7;
  endtask

  // Offer the current op at cycle 0 only, then watch ncyc cycles.
  task automatic run(input int ncyc, input int done_at, input int flush_at,
                     input int ordy_from, input bit use_div,
                     input logic [1:0] exp_ctl, input int exp_res);
    n_st = 0; n_start = 0; n_ov = 0; n_ovw = 0; n_to = 0; to_c = -1;
    n_ctlbad = 0; n_resbad = 0;
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      bus.in_valid  = (c == 0);
      flush         = (c == flush_at);
      mul_done      = !use_div && (c == done_at);
      div_done      = use_div && (c == done_at);
      bus.out_ready = (c >= ordy_from);
      #1;
      if (stall) n_st++;
      if (mulstart || divstart) n_start++;
      if (bus.out_valid) begin
        n_ov++;
        if (!bus.out_ready) n_ovw++;
        if (int'(ifuresctl) != exp_res) n_resbad++;
      end
      if (timeout) begin
        n_to++;
        to_c = c;
      end
      if ((c == 0 || stall) && ((use_div ? divctl : mulctl) != exp_ctl)) n_ctlbad++;
    end
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    mul_done     = 1'b0;
    div_done     = 1'b0;
  endtask

  // {opcode, func3, func7b50, expected aluctl}
  logic [15:0] alu_vec [13];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    alu_vec = '{
      {OP_R,   3'b000, 2'b10, 4'b0001},
      {OP_I,   3'b000, 2'b10, 4'b0000},
      {OP_R,   3'b000, 2'b00, 4'b0000},
      {OP_R,   3'b101, 2'b10, 4'b0111},
      {OP_I,   3'b101, 2'b00, 4'b0110},
      {OP_I,   3'b101, 2'b10, 4'b0111},
      {OP_R,   3'b011, 2'b00, 4'b1001},
      {OP_I,   3'b111, 2'b00, 4'b0100},
      {OP_R,   3'b110, 2'b00, 4'b0011},
      {OP_R,   3'b001, 2'b00, 4'b0101},
      {OP_I,   3'b010, 2'b00, 4'b1000},
      {OP_I,   3'b100, 2'b00, 4'b0010},
      {OP_LUI, 3'b000, 2'b10, 4'b0000}
    };
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op(7'd0, 3'd0, 2'd0);

    // reset state
    cyc();
    cyc();
    chk("rst_stall", stall, 0);
    chk("rst_outv", bus.out_valid, 0);
    chk("rst_mulstart", mulstart, 0);
    chk("rst_divstart", divstart, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_res", ifuresctl, 0);
    chk("rst_alu", aluctl, 0);
    chk("rst_mulctl", mulctl, 0);
    chk("rst_divctl", divctl, 0);
    rst_n = 1'b1;

    // ALU decode and zero-latency pass-through
    for (int i = 0; i < 13; i++) begin
      cyc();
      set_op(alu_vec[i][15:9], alu_vec[i][8:6], alu_vec[i][5:4]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("alu%0d_ctl", i), aluctl, int'(alu_vec[i][3:0]));
      chk($sformatf("alu%0d_outv", i), bus.out_valid, 1);
      chk($sformatf("alu%0d_inrdy", i), bus.in_ready, 1);
      chk($sformatf("alu%0d_res", i), ifuresctl, 0);
      chk($sformatf("alu%0d_stall", i), stall, 0);
    end
    bus.out_ready = 1'b0;
    #1;
    chk("alu_bp_inrdy", bus.in_ready, 0);
    chk("alu_bp_outv", bus.out_valid, 1);
    bus.in_valid = 1'b0;

    // mulh, done 4 cycles after start
    set_op(OP_R, 3'b001, 2'b01);
    run(8, 4, -1, 0, 1'b0, 2'b01, 1);
    chk("mulh_stall", n_st, 5);
    chk("mulh_start", n_start, 1);
    chk("mulh_outv", n_ov, 1);
    chk("mulh_ctl", n_ctlbad, 0);
    chk("mulh_res", n_resbad, 0);
    chk("mulh_to", n_to, 0);

    // remu, done after 10 cycles, out_ready held low 3 result cycles
    set_op(OP_R, 3'b111, 2'b01);
    run(17, 10, -1, 14, 1'b1, 2'b11, 2);
    chk("remu_stall", n_st, 14);
    chk("remu_start", n_start, 1);
    chk("remu_outv", n_ov, 4);
    chk("remu_outv_wait", n_ovw, 3);
    chk("remu_ctl", n_ctlbad, 0);
    chk("remu_res", n_resbad, 0);
    chk("remu_idle", stall, 0);

    // div never completes: watchdog abort
    set_op(OP_R, 3'b100, 2'b01);
    run(72, -1, -1, 0, 1'b1, 2'b00, 2);
    chk("to_count", n_to, 1);
    chk("to_cycle", to_c, 64);
    chk("to_outv", n_ov, 0);
    chk("to_stall", n_st, 64);
    chk("to_idle", stall, 0);

    // done in the very cycle the watchdog would fire: done wins
    run(68, 64, -1, 0, 1'b1, 2'b00, 2);
    chk("edge_to", n_to, 0);
    chk("edge_outv", n_ov, 1);
    chk("edge_stall", n_st, 65);

    // flush in MUL_WAIT, late done ignored
    set_op(OP_R, 3'b000, 2'b01);
    run(8, 3, 2, 0, 1'b0, 2'b00, 1);
    chk("flush_outv", n_ov, 0);
    chk("flush_stall", n_st, 2);
    chk("flush_to", n_to, 0);

    // flush and done in the same cycle: flush wins
    run(8, 2, 2, 0, 1'b0, 2'b00, 1);
    chk("flushdone_outv", n_ov, 0);
    chk("flushdone_stall", n_st, 2);

    // reset mid DIV_WAIT
    set_op(OP_R, 3'b110, 2'b01);
    run(4, -1, -1, 0, 1'b1, 2'b10, 2);
    chk("prerst_stall", stall, 1);
    chk("prerst_divctl", divctl, 2);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_divctl", divctl, 0);
    chk("midrst_outv", bus.out_valid, 0);
    chk("midrst_res", ifuresctl, 0);
    chk("midrst_timeout", timeout, 0);
    cyc();
    rst_n = 1'b1;
    set_op(OP_I, 3'b100, 2'b00);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("postrst_alu", aluctl, 2);
    chk("postrst_outv", bus.out_valid, 1);
    chk("postrst_inrdy", bus.in_ready, 1);
    chk("postrst_stall", stall, 0);
    bus.in_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
